// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light lamp bus: lamp codes, phase and
// monitor state encodings, error codes and helpers used by the monitor.
// No ports (package).
package semaforo_pkg;

    localparam logic [2:0] LED_RED = 3'b001;
    localparam logic [2:0] LED_AMB = 3'b011;
    localparam logic [2:0] LED_GRN = 3'b010;

    localparam int unsigned STK_W       = 4;
    localparam int unsigned STK_LONG    = 0;
    localparam int unsigned STK_SHORT   = 1;
    localparam int unsigned STK_ORDER   = 2;
    localparam int unsigned STK_ILLEGAL = 3;

    typedef enum logic [1:0] {
        PH_UNKNOWN = 2'd0,
        PH_RED     = 2'd1,
        PH_AMBER   = 2'd2,
        PH_GREEN   = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ST_UNSYNC = 3'd0,
        ST_RED    = 3'd1,
        ST_AMB_UP = 3'd2,
        ST_GREEN  = 3'd3,
        ST_AMB_DN = 3'd4
    } mon_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ILLEGAL = 3'd1,
        ERR_ORDER   = 3'd2,
        ERR_SHORT   = 3'd3,
        ERR_LONG    = 3'd4
    } err_code_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == LED_RED) || (code == LED_AMB) || (code == LED_GRN);
    endfunction

    // Lamp code that must follow the phase currently being tracked.
    function automatic logic [2:0] expected_next(input mon_state_t s);
        case (s)
            ST_RED:    return LED_AMB;
            ST_AMB_UP: return LED_GRN;
            ST_GREEN:  return LED_AMB;
            default:   return LED_RED;
        endcase
    endfunction

    function automatic mon_state_t advance(input mon_state_t s);
        case (s)
            ST_RED:    return ST_AMB_UP;
            ST_AMB_UP: return ST_GREEN;
            ST_GREEN:  return ST_AMB_DN;
            ST_AMB_DN: return ST_RED;
            default:   return ST_UNSYNC;
        endcase
    endfunction

    function automatic phase_t phase_of(input mon_state_t s);
        case (s)
            ST_RED:    return PH_RED;
            ST_AMB_UP: return PH_AMBER;
            ST_GREEN:  return PH_GREEN;
            ST_AMB_DN: return PH_AMBER;
            default:   return PH_UNKNOWN;
        endcase
    endfunction

    function automatic logic [STK_W-1:0] sticky_mask(input err_code_t e);
        logic [STK_W-1:0] m;
        m = '0;
        case (e)
            ERR_ILLEGAL: m[STK_ILLEGAL] = 1'b1;
            ERR_ORDER:   m[STK_ORDER]   = 1'b1;
            ERR_SHORT:   m[STK_SHORT]   = 1'b1;
            ERR_LONG:    m[STK_LONG]    = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Lamp bus plus monitor status signals.
//   led        : lamp code from the light controller
//   phase      : tracked phase (0 unknown, 1 red, 2 amber, 3 green)
//   locked     : sequence is being tracked
//   err_pulse  : one-cycle error strobe
//   err_code   : last error code, held
//   err_sticky : per-type sticky flags [ILLEGAL,ORDER,SHORT,LONG]
//   cycles_ok  : count of fully verified light cycles
// master = lamp source side, slave = monitor side.
interface semaforo_monitor_if #(
    parameter int unsigned CYC_W = 16
) ();
    import semaforo_pkg::*;

    logic [2:0]       led;
    phase_t           phase;
    logic             locked;
    logic             err_pulse;
    err_code_t        err_code;
    logic [STK_W-1:0] err_sticky;
    logic [CYC_W-1:0] cycles_ok;

    modport master (
        output led,
        input  phase, locked, err_pulse, err_code, err_sticky, cycles_ok
    );

    modport slave (
        input  led,
        output phase, locked, err_pulse, err_code, err_sticky, cycles_ok
    );

endinterface

// File: rtl/phase_timer.sv
// Saturating phase-duration counter with window compares.
//   clk, rst          : clock, async active-high reset
//   i_chg             : lamp code changed this cycle (restarts the count)
//   o_too_short_c     : at a change, measured length below the window
//   o_too_long_c      : at a change, measured length above the window
//   o_timeout_c       : current hold has just passed the window
module phase_timer #(
    parameter int unsigned PHASE_CYCLES = 80000000,
    parameter int unsigned TOL          = 16,
    parameter int unsigned CNT_W        = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic i_chg,
    output logic o_too_short_c,
    output logic o_too_long_c,
    output logic o_timeout_c
);

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(PHASE_CYCLES - TOL);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(PHASE_CYCLES + TOL);
    localparam logic [CNT_W-1:0] TMO_LEN = CNT_W'(PHASE_CYCLES + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_dur;

    // r_dur equals the length of the previous code in the cycle a change is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dur <= '0;
        end else if (i_chg) begin
            r_dur <= CNT_W'(1);
        end else if (r_dur != CNT_MAX) begin
            r_dur <= r_dur + CNT_W'(1);
        end
    end

    assign o_too_short_c = i_chg && (r_dur < MIN_LEN);
    assign o_too_long_c  = i_chg && (r_dur > MAX_LEN);
    assign o_timeout_c   = (r_dur == TMO_LEN);

endmodule

// File: rtl/semaforo_monitor.sv
// Receive-side checker for the lamp bus: locks onto RED->AMBER->GREEN->AMBER->RED,
// times every phase and reports illegal codes, wrong order and bad lengths.
//   clk, rst : clock, async active-high reset
//   bus      : semaforo_monitor_if slave (led in; phase, locked, err_pulse,
//              err_code, err_sticky, cycles_ok out, all registered)
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 80000000,
    parameter int unsigned TOL          = 16,
    parameter int unsigned CNT_W        = 28,
    parameter int unsigned CYC_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    semaforo_monitor_if.slave bus
);

    logic [2:0]       r_led_q;
    logic             w_chg;
    logic             w_too_short;
    logic             w_too_long;
    logic             w_timeout;

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    err_code_t        w_err;

    phase_t           r_phase,      w_phase_d;
    logic             r_locked,     w_locked_d;
    logic             r_err_pulse,  w_err_pulse_d;
    err_code_t        r_err_code,   w_err_code_d;
    logic [STK_W-1:0] r_err_sticky, w_err_sticky_d;
    logic [CYC_W-1:0] r_cycles_ok,  w_cycles_ok_d;

    // Previous lamp code for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_q <= 3'b000;
        end else begin
            r_led_q <= bus.led;
        end
    end

    assign w_chg = (bus.led != r_led_q);

    phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .TOL          (TOL),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_chg         (w_chg),
        .o_too_short_c (w_too_short),
        .o_too_long_c  (w_too_long),
        .o_timeout_c   (w_timeout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UNSYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and error classification; any error drops back to UNSYNC.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = ERR_NONE;
        if (r_state == ST_UNSYNC) begin
            if (w_chg && (bus.led == LED_RED)) begin
                w_state_nxt = ST_RED;
            end
        end else if (w_chg) begin
            if (!is_legal(bus.led)) begin
                w_err = ERR_ILLEGAL;
            end else if (bus.led != expected_next(r_state)) begin
                w_err = ERR_ORDER;
            end else if (w_too_short) begin
                w_err = ERR_SHORT;
            end else if (w_too_long) begin
                w_err = ERR_LONG;
            end else begin
                w_state_nxt = advance(r_state);
            end
        end else if (w_timeout) begin
            // Only reachable once per stall: the error leaves the locked states.
            w_err = ERR_LONG;
        end
        if (w_err != ERR_NONE) begin
            w_state_nxt = ST_UNSYNC;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        w_phase_d      = phase_of(w_state_nxt);
        w_locked_d     = (w_state_nxt != ST_UNSYNC);
        w_err_pulse_d  = (w_err != ERR_NONE);
        w_err_code_d   = r_err_code;
        w_err_sticky_d = r_err_sticky;
        w_cycles_ok_d  = r_cycles_ok;
        if (w_err != ERR_NONE) begin
            w_err_code_d   = w_err;
            w_err_sticky_d = r_err_sticky | sticky_mask(w_err);
        end
        if ((r_state == ST_AMB_DN) && (w_state_nxt == ST_RED)) begin
            w_cycles_ok_d = r_cycles_ok + CYC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= PH_UNKNOWN;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_sticky <= '0;
            r_cycles_ok  <= '0;
        end else begin
            r_phase      <= w_phase_d;
            r_locked     <= w_locked_d;
            r_err_pulse  <= w_err_pulse_d;
            r_err_code   <= w_err_code_d;
            r_err_sticky <= w_err_sticky_d;
            r_cycles_ok  <= w_cycles_ok_d;
        end
    end

    assign bus.phase      = r_phase;
    assign bus.locked     = r_locked;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_code   = r_err_code;
    assign bus.err_sticky = r_err_sticky;
    assign bus.cycles_ok  = r_cycles_ok;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed scenarios plus random lamp sequences,
// checked every cycle against a sequence/run-length reference model.
module tb_semaforo_monitor;
    import semaforo_pkg::*;

    localparam int unsigned P     = 20;
    localparam int unsigned T     = 2;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned CYC_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    semaforo_monitor_if #(.CYC_W(CYC_W)) bus ();

    semaforo_monitor #(
        .PHASE_CYCLES (P),
        .TOL          (T),
        .CNT_W        (CNT_W),
        .CYC_W        (CYC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    // Reference model: position in the 4-step lamp cycle plus run length of the held code.
    logic [2:0]       m_prev;
    int               m_run;
    bit               m_locked;
    int               m_idx;
    logic [1:0]       e_phase;
    logic             e_locked;
    logic             e_pulse;
    logic [2:0]       e_code;
    logic [3:0]       e_sticky;
    logic [CYC_W-1:0] e_cycles;

    function automatic logic [2:0] seq_code(input int i);
        case (i)
            0:       return LED_RED;
            1:       return LED_AMB;
            2:       return LED_GRN;
            default: return LED_AMB;
        endcase
    endfunction

    function automatic logic [1:0] seq_phase(input int i);
        case (i)
            0:       return 2'd1;
            2:       return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [26:0] got_vec();
        return {bus.phase, bus.locked, bus.err_pulse, bus.err_code, bus.err_sticky, bus.cycles_ok};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {e_phase, e_locked, e_pulse, e_code, e_sticky, e_cycles};
    endfunction

    task automatic model_reset();
        m_prev = 3'b000; m_run = 0; m_locked = 0; m_idx = 0;
        e_phase = 2'd0; e_locked = 1'b0; e_pulse = 1'b0;
        e_code = 3'd0; e_sticky = 4'd0; e_cycles = '0;
    endtask

    task automatic model_step(input logic [2:0] v);
        int err;
        err = 0;
        if (v != m_prev) begin
            if (!m_locked) begin
                if (v == LED_RED) begin
                    m_locked = 1;
                    m_idx    = 0;
                end
            end else if (!(v == LED_RED || v == LED_AMB || v == LED_GRN)) begin
                err = 1;
            end else if (v != seq_code((m_idx + 1) % 4)) begin
                err = 2;
            end else if (m_run < int'(P - T)) begin
                err = 3;
            end else if (m_run > int'(P + T)) begin
                err = 4;
            end else begin
                m_idx = (m_idx + 1) % 4;
                if (m_idx == 0) e_cycles = e_cycles + 1'b1;
            end
            m_run = 1;
        end else begin
            if (m_locked && m_run == int'(P + T + 1)) err = 4;
            m_run++;
        end
        m_prev = v;
        if (err != 0) begin
            m_locked = 0;
            e_code   = 3'(err);
            e_sticky = e_sticky | 4'(1 << (4 - err));
        end
        e_pulse  = (err != 0);
        e_locked = m_locked;
        e_phase  = m_locked ? seq_phase(m_idx) : 2'd0;
    endtask

    // Apply one lamp code for one clock, advance the model, sample after the edge.
    task automatic drive(input logic [2:0] v);
        bus.led = v;
        @(posedge clk);
        model_step(v);
        #1;
        if (bus.err_pulse) pulses++;
    endtask

    task automatic test_reset();
        bus.led = 3'b000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (got_vec() !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h exp %h", got_vec(), 27'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_nominal();
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) begin
                for (int n = 0; n < int'(P); n++) begin
                    drive(seq_code(k));
                    n_tests++;
                    if (got_vec() !== exp_vec()) begin
                        n_fail++;
                        $display("FAIL nominal c%0d k%0d n%0d: got %h exp %h", c, k, n, got_vec(), exp_vec());
                    end
                    if (c == 0 && k == 0 && n == 0) begin
                        n_tests++;
                        if (bus.locked !== 1'b1) begin
                            n_fail++;
                            $display("FAIL nominal_lock: got %b exp 1", bus.locked);
                        end
                    end
                end
            end
        end
        n_tests++;
        if (bus.cycles_ok !== 16'd2 || pulses != 0) begin
            n_fail++;
            $display("FAIL nominal_end: cycles_ok %0d pulses %0d exp 2 and 0", bus.cycles_ok, pulses);
        end
    endtask

    task automatic test_short();
        logic [2:0] cq[$] = '{LED_RED, LED_AMB, LED_RED};
        int         lq[$] = '{17, 20, 20};
        pulses = 0;
        for (int s = 0; s < cq.size(); s++) begin
            for (int n = 0; n < lq[s]; n++) begin
                drive(cq[s]);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL short s%0d n%0d: got %h exp %h", s, n, got_vec(), exp_vec());
                end
            end
        end
        n_tests++;
        if (bus.err_code !== 3'd3 || bus.err_sticky !== 4'b0010 || pulses != 1 || bus.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL short_end: code %0d sticky %b pulses %0d locked %b exp 3 0010 1 1",
                     bus.err_code, bus.err_sticky, pulses, bus.locked);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] cq[$] = '{LED_AMB, LED_GRN};
        int         lq[$] = '{20, 80};
        pulses = 0;
        for (int s = 0; s < cq.size(); s++) begin
            for (int n = 0; n < lq[s]; n++) begin
                drive(cq[s]);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL timeout s%0d n%0d: got %h exp %h", s, n, got_vec(), exp_vec());
                end
            end
        end
        n_tests++;
        if (bus.err_code !== 3'd4 || bus.err_sticky !== 4'b0011 || pulses != 1 || bus.locked !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_end: code %0d sticky %b pulses %0d locked %b exp 4 0011 1 0",
                     bus.err_code, bus.err_sticky, pulses, bus.locked);
        end
    endtask

    task automatic test_order_illegal();
        logic [2:0] cq[$] = '{LED_RED, LED_AMB, LED_RED, LED_AMB, LED_RED, 3'b111};
        int         lq[$] = '{20, 20, 5, 3, 20, 4};
        pulses = 0;
        for (int s = 0; s < cq.size(); s++) begin
            for (int n = 0; n < lq[s]; n++) begin
                drive(cq[s]);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL order s%0d n%0d: got %h exp %h", s, n, got_vec(), exp_vec());
                end
            end
            if (s == 2) begin
                n_tests++;
                if (bus.err_code !== 3'd2) begin
                    n_fail++;
                    $display("FAIL order_code: got %0d exp 2", bus.err_code);
                end
            end
        end
        n_tests++;
        if (bus.err_code !== 3'd1 || bus.err_sticky !== 4'b1111 || pulses != 2) begin
            n_fail++;
            $display("FAIL illegal_end: code %0d sticky %b pulses %0d exp 1 1111 2",
                     bus.err_code, bus.err_sticky, pulses);
        end
    endtask

    task automatic test_boundaries();
        logic [2:0] cq[$] = '{LED_RED, LED_AMB, LED_GRN, LED_AMB, LED_RED,
                              LED_AMB, LED_GRN, LED_AMB, LED_RED, LED_AMB};
        int         lq[$] = '{18, 22, 18, 22, 22, 20, 20, 20, 23, 5};
        pulses = 0;
        for (int s = 0; s < cq.size(); s++) begin
            for (int n = 0; n < lq[s]; n++) begin
                drive(cq[s]);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL bound s%0d n%0d: got %h exp %h", s, n, got_vec(), exp_vec());
                end
            end
        end
        n_tests++;
        if (bus.err_code !== 3'd4 || pulses != 1 || bus.cycles_ok !== 16'd5) begin
            n_fail++;
            $display("FAIL bound_end: code %0d pulses %0d cycles_ok %0d exp 4 1 5",
                     bus.err_code, pulses, bus.cycles_ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] cq[$] = '{LED_RED, LED_AMB, LED_GRN, LED_AMB, LED_RED, LED_AMB, LED_GRN,
                              LED_AMB, LED_RED, LED_AMB, LED_GRN};
        int         lq[$] = '{20, 20, 20, 20, 20, 20, 20, 20, 20, 20, 10};
        logic [2:0] rq[$] = '{LED_GRN, LED_RED, LED_AMB};
        int         rl[$] = '{5, 20, 3};
        for (int s = 0; s < cq.size(); s++) begin
            for (int n = 0; n < lq[s]; n++) begin
                drive(cq[s]);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rstmid s%0d n%0d: got %h exp %h", s, n, got_vec(), exp_vec());
                end
            end
        end
        rst = 1'b1;
        #2;
        n_tests++;
        if (got_vec() !== 27'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h exp %h", got_vec(), 27'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int s = 0; s < rq.size(); s++) begin
            for (int n = 0; n < rl[s]; n++) begin
                drive(rq[s]);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL relock s%0d n%0d: got %h exp %h", s, n, got_vec(), exp_vec());
                end
            end
        end
        n_tests++;
        if (bus.locked !== 1'b1 || bus.cycles_ok !== 16'd0 || bus.err_sticky !== 4'd0) begin
            n_fail++;
            $display("FAIL relock_end: locked %b cycles_ok %0d sticky %b exp 1 0 0000",
                     bus.locked, bus.cycles_ok, bus.err_sticky);
        end
    endtask

    task automatic test_random();
        int         gi;
        int         r;
        int         len;
        logic [2:0] code;
        gi = 3;
        for (int s = 0; s < 60; s++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                gi   = (gi + 1) % 4;
                code = seq_code(gi);
                len  = int'($urandom_range(P - T - 2, P + T + 2));
            end else if (r < 9) begin
                code = seq_code(int'($urandom_range(0, 2)));
                len  = int'($urandom_range(1, 30));
            end else begin
                code = 3'($urandom_range(0, 7));
                len  = int'($urandom_range(1, 5));
            end
            for (int n = 0; n < len; n++) begin
                drive(code);
                n_tests++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random s%0d n%0d led %b: got %h exp %h", s, n, code, got_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        bus.led = 3'b000;
        model_reset();
        test_reset();
        test_nominal();
        test_short();
        test_timeout();
        test_order_illegal();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
